// File: rtl/pc_fetch_if.sv
// Control-unit <-> fetch-stage bundle: per-cycle jump controls in, PC/status out.
// The master side is the control unit; pc_fetch takes the slave modport.
interface pc_fetch_if #(
  parameter int AW = 10,
  parameter int OW = 8
) ();
  logic          en;
  logic          s_inc;
  logic          s_rel;
  logic          flag_we;
  logic          alu_zero;
  logic [AW-1:0] dir_abs;
  logic [OW-1:0] off_rel;
  logic [AW-1:0] pc;
  logic          zero;
  logic          halted;
  logic          wrap;
  logic [15:0]   icount;

  modport master (
    output en, s_inc, s_rel, flag_we, alu_zero, dir_abs, off_rel,
    input  pc, zero, halted, wrap, icount
  );

  modport slave (
    input  en, s_inc, s_rel, flag_we, alu_zero, dir_abs, off_rel,
    output pc, zero, halted, wrap, icount
  );
endinterface

// File: rtl/pc_fetch.sv
// Program-counter fetch stage: absolute/sequential/relative next-PC, zero flag,
// sticky jump-to-self halt, wrap pulse and saturating executed-cycle counter.
module pc_fetch #(
  parameter int AW = 10,
  parameter int OW = 8
) (
  input logic       clk,
  input logic       reset,
  pc_fetch_if.slave bus
);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  localparam logic [AW-1:0] PC_ONE = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW-1:0] PC_MAX = {AW{1'b1}};

  state_t            r_state;
  state_t            w_state_nxt;
  logic [AW-1:0]     r_pc;
  logic              r_zero;
  logic              r_wrap;
  logic [15:0]       r_icount;

  logic [AW+OW-1:0]  w_off_wide;
  logic [AW-1:0]     w_off_ext;
  logic [AW-1:0]     w_pc_nxt;
  logic              w_adv;
  logic              w_seq_wrap;

  // Sign-extend then truncate, so any OW/AW ratio reduces modulo 2^AW.
  assign w_off_wide = {{AW{bus.off_rel[OW-1]}}, bus.off_rel};
  assign w_off_ext  = w_off_wide[AW-1:0];

  always_comb begin
    w_pc_nxt = r_pc + PC_ONE;
    if (!bus.s_inc) begin
      w_pc_nxt = bus.dir_abs;
    end else if (bus.s_rel) begin
      w_pc_nxt = r_pc + w_off_ext;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_adv       = 1'b0;
    w_seq_wrap  = 1'b0;
    case (r_state)
      ST_RUN: begin
        w_adv      = bus.en;
        w_seq_wrap = bus.en && bus.s_inc && !bus.s_rel && (r_pc == PC_MAX);
        if (bus.en && (w_pc_nxt == r_pc)) begin
          w_state_nxt = ST_HALT;
        end
      end
      ST_HALT: begin
        w_state_nxt = ST_HALT;
      end
      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase
  end

  // The halting edge itself still counts and still loads the flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc     <= '0;
      r_zero   <= 1'b0;
      r_wrap   <= 1'b0;
      r_icount <= '0;
    end else begin
      r_wrap <= w_seq_wrap;
      if (w_adv) begin
        r_pc <= w_pc_nxt;
        if (bus.flag_we) begin
          r_zero <= bus.alu_zero;
        end
        if (r_icount != 16'hFFFF) begin
          r_icount <= r_icount + 16'd1;
        end
      end
    end
  end

  assign bus.pc     = r_pc;
  assign bus.zero   = r_zero;
  assign bus.halted = (r_state == ST_HALT);
  assign bus.wrap   = r_wrap;
  assign bus.icount = r_icount;

endmodule

// File: tb/tb_pc_fetch.sv
// Directed scenarios plus randomized traffic against an integer-arithmetic model.
module tb_pc_fetch;

  localparam int AW   = 10;
  localparam int OW   = 8;
  localparam int PMOD = 1 << AW;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_err;
  bit   chk_on;

  int   m_pc;
  bit   m_zero;
  bit   m_halted;
  bit   m_wrap;
  int   m_icount;

  pc_fetch_if #(.AW(AW), .OW(OW)) bus ();

  pc_fetch #(.AW(AW), .OW(OW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Outputs only move on the rising edge; compare on the falling edge.
  always @(negedge clk) begin
    if (chk_on) begin
      n_chk = n_chk + 1;
      if (bus.pc !== m_pc[AW-1:0] || bus.zero !== m_zero || bus.halted !== m_halted ||
          bus.wrap !== m_wrap || bus.icount !== m_icount[15:0]) begin
        n_err = n_err + 1;
        $display("FAIL model t=%0t pc=%0d/%0d zero=%b/%b halted=%b/%b wrap=%b/%b icount=%0d/%0d (got/want)",
                 $time, bus.pc, m_pc, bus.zero, m_zero, bus.halted, m_halted,
                 bus.wrap, m_wrap, bus.icount, m_icount);
      end
    end
  end

  task automatic lit(input string nm, input int act, input int exp);
    n_chk = n_chk + 1;
    if (act != exp) begin
      n_err = n_err + 1;
      $display("FAIL %s got %0d want %0d", nm, act, exp);
    end
  endtask

  // One clock: drive inputs, advance the model, return just after the edge.
  task automatic cyc(input bit rst, input bit e, input bit inc, input bit rel,
                     input bit fwe, input bit az, input int da, input int off);
    int nxt;
    int sext;
    @(negedge clk);
    #1;
    reset        = rst;
    bus.en       = e;
    bus.s_inc    = inc;
    bus.s_rel    = rel;
    bus.flag_we  = fwe;
    bus.alu_zero = az;
    bus.dir_abs  = da[AW-1:0];
    bus.off_rel  = off[OW-1:0];
    if (rst) begin
      m_pc = 0; m_zero = 0; m_halted = 0; m_wrap = 0; m_icount = 0;
    end else if (e && !m_halted) begin
      sext = (off[OW-1:0] >= (1 << (OW-1))) ? int'(off[OW-1:0]) - (1 << OW) : int'(off[OW-1:0]);
      if (!inc)     nxt = da % PMOD;
      else if (rel) nxt = (m_pc + sext + PMOD) % PMOD;
      else          nxt = (m_pc + 1) % PMOD;
      m_wrap = inc && !rel && (m_pc == PMOD - 1);
      if (nxt == m_pc) m_halted = 1;
      if (fwe) m_zero = az;
      if (m_icount < 65535) m_icount = m_icount + 1;
      m_pc = nxt;
    end else begin
      m_wrap = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic seq(input int n);
    for (int i = 0; i < n; i++) cyc(0, 1, 1, 0, 0, 0, 0, 0);
  endtask

  task automatic jmp(input int target);
    cyc(0, 1, 0, 0, 0, 0, target, 0);
  endtask

  initial begin
    n_chk  = 0;
    n_err  = 0;
    chk_on = 0;
    reset  = 1'b1;
    bus.en = 0; bus.s_inc = 0; bus.s_rel = 0; bus.flag_we = 0; bus.alu_zero = 0;
    bus.dir_abs = '0; bus.off_rel = '0;

    cyc(1, 1, 1, 0, 1, 1, 5, 0);
    chk_on = 1;
    cyc(1, 1, 0, 1, 1, 1, 9, 3);
    lit("rst_pc", bus.pc, 0);
    lit("rst_icount", bus.icount, 0);
    lit("rst_halted", bus.halted, 0);
    lit("rst_zero", bus.zero, 0);

    seq(5);
    lit("seq_pc", bus.pc, 5);
    lit("seq_icount", bus.icount, 5);

    jmp(10);
    cyc(0, 1, 1, 1, 0, 0, 0, 'hFC);
    lit("rel_back_pc", bus.pc, 6);
    cyc(0, 1, 1, 1, 0, 0, 0, 'h05);
    lit("rel_fwd_pc", bus.pc, 11);

    jmp(3);
    jmp(20);
    lit("abs_pc", bus.pc, 20);
    lit("abs_not_halted", bus.halted, 0);
    jmp(20);
    lit("self_halted", bus.halted, 1);
    seq(3);
    lit("halt_pc", bus.pc, 20);
    lit("halt_icount", bus.icount, 11);

    cyc(1, 1, 1, 0, 1, 1, 0, 0);
    lit("midrst_pc", bus.pc, 0);
    lit("midrst_halted", bus.halted, 0);
    lit("midrst_icount", bus.icount, 0);
    lit("midrst_wrap", bus.wrap, 0);

    jmp(1023);
    seq(1);
    lit("wrap_pc", bus.pc, 0);
    lit("wrap_pulse", bus.wrap, 1);
    seq(1);
    lit("wrap_clear", bus.wrap, 0);
    jmp(2);
    cyc(0, 1, 1, 1, 0, 0, 0, 'hFC);
    lit("relwrap_pc", bus.pc, 1022);
    lit("relwrap_nopulse", bus.wrap, 0);

    cyc(0, 1, 1, 0, 1, 1, 0, 0);
    lit("flag_set", bus.zero, 1);
    cyc(0, 1, 1, 0, 0, 0, 0, 0);
    lit("flag_hold", bus.zero, 1);
    cyc(0, 0, 1, 0, 1, 0, 0, 0);
    lit("en0_zero", bus.zero, 1);
    lit("en0_pc", bus.pc, 0);
    lit("en0_wrap", bus.wrap, 0);

    for (int i = 0; i < 3000; i++) begin
      bit r, e, inc, rel, fwe, az;
      int da, off;
      r   = ($urandom_range(0, 99) == 0);
      e   = ($urandom_range(0, 9) < 8);
      inc = $urandom_range(0, 2) != 0;
      rel = $urandom_range(0, 1);
      fwe = $urandom_range(0, 1);
      az  = $urandom_range(0, 1);
      da  = ($urandom_range(0, 39) == 0) ? m_pc : int'($urandom_range(0, PMOD - 1));
      off = ($urandom_range(0, 39) == 0) ? 0 : int'($urandom_range(0, 255));
      if ($urandom_range(0, 19) == 0) begin
        inc = 0;
        da  = PMOD - 1;
      end
      cyc(r, e, inc, rel, fwe, az, da, off);
    end

    @(negedge clk);
    #1;
    chk_on = 0;
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
